reorder_tag_manager: RTL
========================

REORDER_TAG_MANAGER -- requirements
Module: reorder_tag_manager

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 6, the width of every tag port.
REQ-002 SHALL have parameter CIRCULAR_BUFFER_SIZE, default 3 (50 in production), the number of tag slots; legal tags are 0..CIRCULAR_BUFFER_SIZE-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port tag_TDATA, output, TAG_WIDTH, the next tag to issue to an ingress packet.
REQ-006 SHALL have port tag_TVALID, output, 1, high when the tag_TDATA slot is free.
REQ-007 SHALL have port tag_TREADY, input, 1, ingress accepts the tag; a transfer occurs when tag_TVALID and tag_TREADY are both high.
REQ-008 SHALL have ports verdict_valid (input, 1), verdict_tag (input, TAG_WIDTH) and verdict_accept (input, 1), the filter verdict for one tag.
REQ-009 SHALL have port reorder_tag_out, input, TAG_WIDTH, the circular buffer's head tag to look up.
REQ-010 SHALL have port packet_status, output, 2, the status of reorder_tag_out: 00 pending, 01 rejected, 11 accepted.
REQ-011 SHALL have port release_valid, input, 1, a one-cycle pulse when the buffer finishes forwarding or dropping its head packet.
REQ-012 SHALL have ports occupancy (output, TAG_WIDTH+1, allocated slot count) and err_sticky (output, 3, sticky error flags).

Function
REQ-013 SHALL hold per slot one state: FREE, PENDING, REJECTED or ACCEPTED.
REQ-014 SHALL keep a tail pointer (next issue) and a head pointer (next release), each wrapping from CIRCULAR_BUFFER_SIZE-1 to 0.
REQ-015 SHALL drive tag_TDATA from the tail pointer, and drive tag_TVALID high iff the tail slot is FREE (equivalently occupancy < CIRCULAR_BUFFER_SIZE).
REQ-016 SHALL, on a tag transfer, move the tail slot to PENDING, advance tail and increment occupancy the next cycle.
REQ-017 SHALL, on verdict_valid for a PENDING slot, move that slot to ACCEPTED if verdict_accept else REJECTED.
REQ-018 SHALL ignore a verdict to a FREE or already-decided slot and set err_sticky[0] (unallocated) or err_sticky[1] (duplicate).
REQ-019 SHALL drive packet_status combinationally from the registered table; a FREE slot reads 00; an out-of-range reorder_tag_out reads 00.
REQ-020 SHALL make a verdict written in cycle N visible on packet_status in cycle N+1, with no same-cycle bypass.
REQ-021 SHALL, on release_valid with the head slot decided, move the head slot to FREE, advance head and decrement occupancy.
REQ-022 SHALL ignore release_valid when the head slot is PENDING or FREE and set err_sticky[2].
REQ-023 SHALL, on a simultaneous transfer and release, apply both, leaving occupancy unchanged.
REQ-024 SHALL evaluate tag_TVALID when full from registered state only: a release in the same cycle enables issue from the next cycle.
REQ-025 SHALL judge a verdict and a transfer naming the same slot in one cycle against the pre-edge state, so the verdict counts as unallocated.
REQ-026 SHALL apply a verdict and a release on different slots in the same cycle independently.

Reset
REQ-027 SHALL on rst set every slot to FREE, head=0, tail=0, occupancy=0 and err_sticky=0, which makes tag_TVALID=1, tag_TDATA=0 and packet_status=00.
REQ-028 SHALL, if rst is asserted mid-operation, discard all outstanding tags and verdicts immediately without waiting for a clock edge.
REQ-029 SHALL clear err_sticky only by rst.

Structure
REQ-030 SHALL take the status encodings PENDING=2'b00, REJECTED=2'b01, ACCEPTED=2'b11 from a shared package also used by circular_buffer.
REQ-031 SHALL place the FREE marker, a per-slot valid bit, in this module, not in the package.
REQ-032 SHALL factor the wrapping pointer into one sub-module, mod_counter (parameter MODULUS; ports clk, rst, inc, value), instantiated for head and tail.

Verification
REQ-033 SHALL verify reset then three transfers: tag_TDATA steps 0,1,2, then tag_TVALID=0 with occupancy=3.
REQ-034 SHALL verify verdict(tag 1, accept) at cycle N: packet_status for reorder_tag_out=1 is 00 in cycle N and 11 in cycle N+1.
REQ-035 SHALL verify, when full, release of decided head 0 together with tag_TREADY=1: no transfer that cycle; next cycle tag_TVALID=1, tag_TDATA=0, occupancy=2.
REQ-036 SHALL verify release with head PENDING: head, occupancy and table unchanged, err_sticky=3'b100.
REQ-037 SHALL verify a second verdict on tag 2 (reject after accept): status stays 11 and err_sticky[1]=1; a verdict to a FREE tag sets err_sticky[0]=1.
REQ-038 SHALL verify rst pulsed between clock edges mid-stream: all slots FREE and occupancy=0 before the next edge.

Source files
------------

// File: rtl/reorder_tag_manager_pkg.sv
// Shared verdict status encodings used by reorder_tag_manager and circular_buffer.
// Slot occupancy (the FREE marker) is kept by the tag manager, not encoded here.
package reorder_tag_manager_pkg;

   typedef enum logic [1:0] {
      ST_PENDING  = 2'b00,
      ST_REJECTED = 2'b01,
      ST_ACCEPTED = 2'b11
   } status_t;

   function automatic status_t verdict_status(input logic accept);
      return accept ? ST_ACCEPTED : ST_REJECTED;
   endfunction

endpackage

// File: rtl/reorder_tag_manager_mod_counter.sv
// Wrapping pointer: counts 0..MODULUS-1 and wraps to 0, advancing one step per inc.
// Value updates on the clock edge after inc; asynchronous active-high reset to 0.
module mod_counter #(
   parameter int MODULUS = 3,
   parameter int WIDTH   = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (inc) begin
         value <= (value == LAST) ? '0 : value + 1'b1;
      end
   end

endmodule

// File: rtl/reorder_tag_manager.sv
// Issues reorder tags from a slot ring, records filter verdicts per slot and frees slots on release.
// Issue stalls (tag_TVALID low) while the tail slot is allocated; status reads are combinational from registered state.
module reorder_tag_manager
   import reorder_tag_manager_pkg::*;
#(
   parameter int TAG_WIDTH            = 6,
   parameter int CIRCULAR_BUFFER_SIZE = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [TAG_WIDTH-1:0] tag_TDATA,
   output logic                 tag_TVALID,
   input  logic                 tag_TREADY,
   input  logic                 verdict_valid,
   input  logic [TAG_WIDTH-1:0] verdict_tag,
   input  logic                 verdict_accept,
   input  logic [TAG_WIDTH-1:0] reorder_tag_out,
   output logic [1:0]           packet_status,
   input  logic                 release_valid,
   output logic [TAG_WIDTH:0]   occupancy,
   output logic [2:0]           err_sticky
);

   localparam int N  = CIRCULAR_BUFFER_SIZE;
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [TAG_WIDTH:0] OCC_ONE = (TAG_WIDTH + 1)'(1);

   logic [PW-1:0] head, tail;
   logic [N-1:0]  used;
   status_t       st [N];

   logic [N-1:0] at_tail, at_head, at_verdict;
   logic         tail_free, head_decided, v_used, v_pending;
   logic         xfer, rel, v_hit;
   logic [2:0]   err_now;

   mod_counter #(.MODULUS(N), .WIDTH(PW)) u_tail (
      .clk(clk), .rst(rst), .inc(xfer), .value(tail)
   );

   mod_counter #(.MODULUS(N), .WIDTH(PW)) u_head (
      .clk(clk), .rst(rst), .inc(rel), .value(head)
   );

   // Decode pointers and tags per slot so out-of-range tags simply match nothing.
   always_comb begin
      at_tail       = '0;
      at_head       = '0;
      at_verdict    = '0;
      tail_free     = 1'b0;
      head_decided  = 1'b0;
      v_used        = 1'b0;
      v_pending     = 1'b0;
      packet_status = 2'b00;
      for (int i = 0; i < N; i++) begin
         at_tail[i]    = (tail == PW'(i));
         at_head[i]    = (head == PW'(i));
         at_verdict[i] = (verdict_tag == TAG_WIDTH'(i));
         if (at_tail[i] && !used[i]) tail_free = 1'b1;
         if (at_head[i] && used[i] && st[i] != ST_PENDING) head_decided = 1'b1;
         if (at_verdict[i]) begin
            v_used    = used[i];
            v_pending = (st[i] == ST_PENDING);
         end
         if (reorder_tag_out == TAG_WIDTH'(i) && used[i]) packet_status = st[i];
      end
   end

   assign tag_TDATA  = TAG_WIDTH'(tail);
   assign tag_TVALID = tail_free;
   assign xfer       = tail_free & tag_TREADY;
   assign rel        = release_valid & head_decided;
   assign v_hit      = verdict_valid & v_used & v_pending;
   assign err_now    = {release_valid & ~head_decided,
                        verdict_valid & v_used & ~v_pending,
                        verdict_valid & ~v_used};

   // Transfer, verdict and release always hit distinct slots, so their writes never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         used       <= '0;
         occupancy  <= '0;
         err_sticky <= '0;
         for (int i = 0; i < N; i++) st[i] <= ST_PENDING;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (xfer && at_tail[i]) begin
               used[i] <= 1'b1;
               st[i]   <= ST_PENDING;
            end else if (rel && at_head[i]) begin
               used[i] <= 1'b0;
            end
            if (v_hit && at_verdict[i]) st[i] <= verdict_status(verdict_accept);
         end
         case ({xfer, rel})
            2'b10:   occupancy <= occupancy + OCC_ONE;
            2'b01:   occupancy <= occupancy - OCC_ONE;
            default: occupancy <= occupancy;
         endcase
         err_sticky <= err_sticky | err_now;
      end
   end

endmodule
